// File: rtl/cwhusky_top_core_if.sv
`default_nettype none
// ============================================================================
// cwhusky_top_core_if : host address/strobe bus into the Husky register core
// Rev 1.0
// ============================================================================
interface cwhusky_top_core_if;
  logic [7:0] USB_Addr;
  logic       USB_RDn;
  logic       USB_WRn;
  logic       USB_CEn;

  modport master (output USB_Addr, USB_RDn, USB_WRn, USB_CEn);
  modport slave  (input  USB_Addr, USB_RDn, USB_WRn, USB_CEn);
endinterface
`default_nettype wire

// File: rtl/cwhusky_top_core.sv
`default_nettype none
// ============================================================================
// cwhusky_top_core : USB register file, ADC serial bit-bang, 64-sample capture
// Rev 1.0 -- optional macro CWHUSKY_TRIGOUT_EN: FPGA_TRIGOUT follows capture
// ============================================================================
module cwhusky_top_core (
  input  wire                     clk_usb,
  input  wire                     reset,
  cwhusky_top_core_if.slave       usb,
  inout  wire  [7:0]              USB_Data,
  input  wire                     USB_SPARE0,
  input  wire                     USB_SPARE1,
  input  wire                     ADC_clk_fbp,
  input  wire                     ADC_clk_fbn,
  input  wire                     ADC_OVR_SDOUT,
  input  wire                     FPGA_CDOUT,
  output wire                     ADC_CLKP,
  output wire                     ADC_CLKN,
  output wire                     ADC_SDIO,
  output wire                     ADC_SCLK,
  output wire                     ADC_CSn,
  output wire                     LED_ARMED,
  output wire                     LED_CAP,
  output wire                     LED_CLK1FAIL,
  output wire                     LED_CLK2FAIL,
  output wire                     FPGA_TRIGOUT,
  inout  wire                     USBIOHS2,
  inout  wire                     FPGA_BONUS1,
  inout  wire                     FPGA_BONUS2,
  inout  wire                     FPGA_BONUS3,
  inout  wire                     FPGA_BONUS4,
  inout  wire                     SAM_MISO,
  inout  wire                     SAM_MOSI,
  inout  wire                     SAM_SPCK,
  inout  wire                     SAM_CS,
  inout  wire                     target_PDID,
  inout  wire                     target_PDIC,
  inout  wire                     target_nRST,
  inout  wire                     target_MISO,
  inout  wire                     target_MOSI,
  inout  wire                     target_SCK,
  inout  wire                     target_io1,
  inout  wire                     target_io2,
  inout  wire                     target_io3,
  inout  wire                     target_io4,
  inout  wire                     target_hs1,
  inout  wire                     target_hs2
);

  localparam logic [7:0] ADDR_GAIN     = 8'h00;
  localparam logic [7:0] ADDR_SETTINGS = 8'h01;
  localparam logic [7:0] ADDR_STATUS   = 8'h02;
  localparam logic [7:0] ADDR_DATA     = 8'h03;
  localparam logic [7:0] ADDR_ECHO     = 8'h04;
  localparam logic [7:0] ADDR_ADCSER   = 8'h3C;
  localparam int         FIFO_DEPTH    = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gain_q, settings_q, echo_q;
  logic [6:0] adcser_q;
  logic [7:0] rd_q, rd_d;
  logic       rd_act_q;
  logic [7:0] fifo_mem_q [FIFO_DEPTH];
  logic [6:0] wp_q, rp_q;
  logic [5:0] smp_q, smp_d;

  logic rst_w, wr_w, rd_now_w, set_wr_w, arm_w, trig_w, empty_w;
  logic push_w, pop_w, flush_w, armed_w, capturing_w, done_w;

  // SETTINGS bit0 resets everything except SETTINGS itself
  assign rst_w       = reset | settings_q[0];
  assign wr_w        = ~usb.USB_CEn & ~usb.USB_WRn;
  assign rd_now_w    = ~usb.USB_CEn & ~usb.USB_RDn;
  assign set_wr_w    = wr_w & (usb.USB_Addr == ADDR_SETTINGS);
  assign arm_w       = set_wr_w & USB_Data[3] & ~settings_q[3];
  assign trig_w      = set_wr_w & USB_Data[6];
  assign empty_w     = (wp_q == rp_q);
  assign pop_w       = rd_act_q & ~(rd_now_w & (usb.USB_Addr == ADDR_DATA)) & ~empty_w;
  assign armed_w     = (state_q == ST_ARMED) | (state_q == ST_CAPTURE);
  assign capturing_w = (state_q == ST_CAPTURE);
  assign done_w      = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    push_w  = 1'b0;
    flush_w = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_w) begin
          state_d = ST_ARMED;
          flush_w = 1'b1;
        end
      end
      ST_ARMED: begin
        if (arm_w) begin
          flush_w = 1'b1;
        end else if (trig_w) begin
          state_d = ST_CAPTURE;
          smp_d   = 6'd0;
        end
      end
      ST_CAPTURE: begin
        push_w = 1'b1;
        smp_d  = smp_q + 6'd1;
        if (smp_q == 6'd63) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_d = 8'h00;
    case (usb.USB_Addr)
      ADDR_GAIN:     rd_d = gain_q;
      ADDR_SETTINGS: rd_d = settings_q;
      ADDR_STATUS:   rd_d = {5'b00000, empty_w, done_w, armed_w};
      ADDR_DATA:     rd_d = empty_w ? 8'h00 : fifo_mem_q[rp_q[5:0]];
      ADDR_ECHO:     rd_d = echo_q;
      ADDR_ADCSER:   rd_d = {ADC_OVR_SDOUT, adcser_q};
      default:       rd_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      settings_q <= 8'h00;
      rd_q       <= 8'h00;
    end else begin
      if (set_wr_w) settings_q <= USB_Data;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_usb) begin
    if (rst_w) begin
      state_q  <= ST_IDLE;
      smp_q    <= 6'd0;
      wp_q     <= 7'd0;
      rp_q     <= 7'd0;
      gain_q   <= 8'h00;
      echo_q   <= 8'h00;
      adcser_q <= 7'd0;
      rd_act_q <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      if (flush_w) begin
        wp_q <= 7'd0;
        rp_q <= 7'd0;
      end else begin
        if (push_w) wp_q <= wp_q + 7'd1;
        if (pop_w)  rp_q <= rp_q + 7'd1;
      end
      if (wr_w) begin
        case (usb.USB_Addr)
          ADDR_GAIN:   gain_q   <= USB_Data;
          ADDR_ECHO:   echo_q   <= USB_Data;
          ADDR_ADCSER: adcser_q <= USB_Data[6:0];
          default: ;
        endcase
      end
      // Pop is armed only by a read that actually saw a sample
      rd_act_q <= rd_now_w & (usb.USB_Addr == ADDR_DATA) & ~empty_w;
    end
  end

  always_ff @(posedge clk_usb) begin
    if (push_w && !rst_w) fifo_mem_q[wp_q[5:0]] <= {2'b00, smp_q};
  end

  assign USB_Data     = rd_now_w ? rd_q : {8{1'bz}};
  assign ADC_CLKP     = clk_usb;
  assign ADC_CLKN     = ~clk_usb;
  assign ADC_SDIO     = adcser_q[0];
  assign ADC_SCLK     = adcser_q[4];
  assign ADC_CSn      = adcser_q[6];
  assign LED_ARMED    = armed_w;
  assign LED_CAP      = capturing_w;
  assign LED_CLK1FAIL = 1'b0;
  assign LED_CLK2FAIL = 1'b0;

`ifdef CWHUSKY_TRIGOUT_EN
  assign FPGA_TRIGOUT = capturing_w;
`else
  assign FPGA_TRIGOUT = 1'b0;
`endif

  assign USBIOHS2    = 1'bz;
  assign FPGA_BONUS1 = 1'bz;
  assign FPGA_BONUS2 = 1'bz;
  assign FPGA_BONUS3 = 1'bz;
  assign FPGA_BONUS4 = 1'bz;
  assign SAM_MISO    = 1'bz;
  assign SAM_MOSI    = 1'bz;
  assign SAM_SPCK    = 1'bz;
  assign SAM_CS      = 1'bz;
  assign target_PDID = 1'bz;
  assign target_PDIC = 1'bz;
  assign target_nRST = 1'bz;
  assign target_MISO = 1'bz;
  assign target_MOSI = 1'bz;
  assign target_SCK  = 1'bz;
  assign target_io1  = 1'bz;
  assign target_io2  = 1'bz;
  assign target_io3  = 1'bz;
  assign target_io4  = 1'bz;
  assign target_hs1  = 1'bz;
  assign target_hs2  = 1'bz;

  wire unused_ok_w = ^{USB_SPARE0, USB_SPARE1, ADC_clk_fbp, ADC_clk_fbn, FPGA_CDOUT};

endmodule
`default_nettype wire

// File: tb/tb_cwhusky_top_core.sv
`default_nettype none
// ============================================================================
// tb_cwhusky_top_core : directed bench with a queue-based model of the core
// Rev 1.0
// ============================================================================
module tb_cwhusky_top_core;

  logic       clk, rst, ovr, h_oe, chk_en;
  logic [7:0] h_dout;
  int         n_chk, n_err;

  cwhusky_top_core_if bus ();
  wire [7:0] USB_Data;
  wire adc_clkp, adc_clkn, adc_sdio, adc_sclk, adc_csn;
  wire led_armed, led_cap, led_f1, led_f2, trigout;
  wire z_hs2, z_b1, z_b2, z_b3, z_b4, z_sm0, z_sm1, z_sm2, z_sm3;
  wire z_t0, z_t1, z_t2, z_t3, z_t4, z_t5, z_t6, z_t7, z_t8, z_t9, z_t10, z_t11;

  assign USB_Data = h_oe ? h_dout : {8{1'bz}};

  cwhusky_top_core dut (
    .clk_usb(clk), .reset(rst), .usb(bus), .USB_Data(USB_Data),
    .USB_SPARE0(1'b0), .USB_SPARE1(1'b0), .ADC_clk_fbp(1'b0), .ADC_clk_fbn(1'b0),
    .ADC_OVR_SDOUT(ovr), .FPGA_CDOUT(1'b0),
    .ADC_CLKP(adc_clkp), .ADC_CLKN(adc_clkn), .ADC_SDIO(adc_sdio), .ADC_SCLK(adc_sclk),
    .ADC_CSn(adc_csn), .LED_ARMED(led_armed), .LED_CAP(led_cap),
    .LED_CLK1FAIL(led_f1), .LED_CLK2FAIL(led_f2), .FPGA_TRIGOUT(trigout),
    .USBIOHS2(z_hs2), .FPGA_BONUS1(z_b1), .FPGA_BONUS2(z_b2), .FPGA_BONUS3(z_b3),
    .FPGA_BONUS4(z_b4), .SAM_MISO(z_sm0), .SAM_MOSI(z_sm1), .SAM_SPCK(z_sm2), .SAM_CS(z_sm3),
    .target_PDID(z_t0), .target_PDIC(z_t1), .target_nRST(z_t2), .target_MISO(z_t3),
    .target_MOSI(z_t4), .target_SCK(z_t5), .target_io1(z_t6), .target_io2(z_t7),
    .target_io3(z_t8), .target_io4(z_t9), .target_hs1(z_t10), .target_hs2(z_t11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: registers, capture flags and the sample buffer as a queue
  logic [7:0] m_set, m_gain, m_echo;
  logic [6:0] m_adc;
  logic       m_armed, m_cap, m_done, m_rdprev;
  int         m_k;
  logic [7:0] m_q [$];

  always @(posedge clk) begin : model
    logic was_cap, wr, rda;
    wr  = !bus.USB_CEn && !bus.USB_WRn;
    rda = !bus.USB_CEn && !bus.USB_RDn;
    if (rst) begin
      m_set = 0; m_gain = 0; m_echo = 0; m_adc = 0;
      m_armed = 0; m_cap = 0; m_done = 0; m_rdprev = 0; m_k = 0; m_q.delete();
    end else if (m_set[0]) begin
      m_gain = 0; m_echo = 0; m_adc = 0;
      m_armed = 0; m_cap = 0; m_done = 0; m_rdprev = 0; m_q.delete();
      if (wr && bus.USB_Addr == 8'h01) m_set = h_dout;
    end else begin
      was_cap = m_cap;
      if (m_rdprev && !(rda && bus.USB_Addr == 8'h03) && m_q.size() > 0) void'(m_q.pop_front());
      if (m_cap) begin
        m_q.push_back(8'(m_k));
        m_k++;
        if (m_k == 64) begin m_cap = 0; m_armed = 0; m_done = 1; end
      end
      m_rdprev = rda && bus.USB_Addr == 8'h03;
      if (wr) begin
        case (bus.USB_Addr)
          8'h00: m_gain = h_dout;
          8'h04: m_echo = h_dout;
          8'h3C: m_adc  = h_dout[6:0];
          8'h01: begin
            if (!was_cap) begin
              if (h_dout[3] && !m_set[3]) begin
                m_armed = 1; m_done = 0; m_q.delete();
              end else if (h_dout[6] && m_armed) begin
                m_cap = 1; m_k = 0;
              end
            end
            m_set = h_dout;
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00: return m_gain;
      8'h01: return m_set;
      8'h02: return {5'b0, (m_q.size() == 0), m_done, m_armed};
      8'h03: return (m_q.size() > 0) ? m_q[0] : 8'h00;
      8'h04: return m_echo;
      8'h3C: return {ovr, m_adc};
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the static outputs against the model
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("led_armed", {7'b0, led_armed}, {7'b0, m_armed});
      chk("led_cap",   {7'b0, led_cap},   {7'b0, m_cap});
`ifdef CWHUSKY_TRIGOUT_EN
      chk("trigout",   {7'b0, trigout},   {7'b0, m_cap});
`else
      chk("trigout",   {7'b0, trigout},   8'h00);
`endif
      chk("adc_lines", {5'b0, adc_csn, adc_sclk, adc_sdio}, {5'b0, m_adc[6], m_adc[4], m_adc[0]});
      chk("clk_fail",  {6'b0, led_f1, led_f2}, 8'h00);
      chk("adc_clk",   {6'b0, adc_clkp, adc_clkn}, 8'h01);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.USB_Addr = a; h_dout = d; h_oe = 1; bus.USB_CEn = 0; bus.USB_WRn = 0;
    @(posedge clk); @(negedge clk);
    bus.USB_CEn = 1; bus.USB_WRn = 1; h_oe = 0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
    bus.USB_Addr = a; bus.USB_CEn = 0; bus.USB_RDn = 0;
    @(posedge clk); @(negedge clk);
    chk(nm, USB_Data, exp);
    bus.USB_CEn = 1; bus.USB_RDn = 1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic rd_m(input logic [7:0] a, input string nm);
    rd(a, m_read(a), nm);
  endtask

  logic [7:0] adc_seq [5];
  logic [2:0] line_exp [5];

  initial begin
    n_chk = 0; n_err = 0; chk_en = 0;
    rst = 1; ovr = 0; h_oe = 0; h_dout = 0;
    bus.USB_Addr = 0; bus.USB_CEn = 1; bus.USB_RDn = 1; bus.USB_WRn = 1;
    adc_seq  = '{8'h41, 8'h01, 8'h00, 8'h11, 8'h10};
    line_exp = '{3'b101, 3'b001, 3'b000, 3'b011, 3'b010};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; chk_en = 1;

    rd(8'h00, 8'h00, "gain_after_reset");
    rd(8'h02, 8'h04, "status_after_reset");
    rd(8'h03, 8'h00, "data_after_reset");
    wr(8'h04, 8'hA5);
    rd(8'h04, 8'hA5, "echo_readback");
    wr(8'h00, 8'h33);
    rd_m(8'h00, "gain_readback");
    wr(8'h10, 8'hFF);
    rd(8'h10, 8'h00, "undefined_addr");
    wr(8'h02, 8'hFF);
    rd(8'h02, 8'h04, "status_readonly");

    wr(8'h3C, 8'h11);
    ovr = 1;
    rd(8'h3C, 8'h91, "adcser_ovr_bit");
    ovr = 0;
    rd_m(8'h3C, "adcser_model");

    wr(8'h01, 8'h00);
    wr(8'h01, 8'h01);
    rd(8'h01, 8'h01, "settings_kept_in_soft_reset");
    wr(8'h01, 8'h00);
    rd(8'h02, 8'h04, "status_after_soft_reset");
    rd(8'h00, 8'h00, "gain_after_soft_reset");
    rd(8'h04, 8'h00, "echo_after_soft_reset");
    rd(8'h3C, 8'h00, "adcser_after_soft_reset");
    rd(8'h01, 8'h00, "settings_after_soft_reset");

    for (int i = 0; i < 5; i++) begin
      wr(8'h3C, adc_seq[i]);
      chk("adc_line_seq", {5'b0, adc_csn, adc_sclk, adc_sdio}, {5'b0, line_exp[i]});
    end

    wr(8'h01, 8'h08);
    rd(8'h02, 8'h05, "status_armed");
    wr(8'h01, 8'h48);
    repeat (1000) @(negedge clk);
    rd(8'h02, 8'h02, "status_done");
    for (int i = 0; i < 20; i++) rd(8'h03, 8'(i), "data_sample");
    rd_m(8'h03, "data_model");
    rd_m(8'h02, "status_model");

    wr(8'h01, 8'h01);
    wr(8'h01, 8'h00);
    wr(8'h01, 8'h40);
    rd(8'h02, 8'h04, "status_trigger_unarmed");
    rd(8'h03, 8'h00, "data_trigger_unarmed");

    wr(8'h01, 8'h08);
    wr(8'h01, 8'h48);
    repeat (10) @(negedge clk);
    rd(8'h02, 8'h01, "status_capturing");
    rd(8'h03, 8'h00, "data_mid_capture");
    wr(8'h01, 8'h00);
    wr(8'h01, 8'h08);
    chk("rearm_ignored_cap", {7'b0, led_cap}, 8'h01);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0;
    #1;
    chk("cap_led_after_reset", {7'b0, led_cap}, 8'h00);
    chk("trigout_after_reset", {7'b0, trigout}, 8'h00);
    @(negedge clk);
    rd(8'h02, 8'h04, "status_after_abort");
    rd(8'h03, 8'h00, "data_after_abort");

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cwhusky_top_core.md
CWHUSKY_TOP_CORE -- requirements
Module: cwhusky_top

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk_usb  in  1  sole clock; every register updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 USB_Data  inout  8  host data bus; driven only while USB_CEn=0 and USB_RDn=0, otherwise Z.
REQ-005 USB_Addr  in  8  register address.
REQ-006 USB_RDn / USB_WRn / USB_CEn  in  1 each  active-low read strobe, write strobe and chip enable.
REQ-007 USB_SPARE0/1, ADC_clk_fbp/n, ADC_OVR_SDOUT, FPGA_CDOUT  in  1 each; only ADC_OVR_SDOUT is used.
REQ-008 ADC_CLKP / ADC_CLKN  out  1 each  carry clk_usb and its inverse.
REQ-009 ADC_SDIO / ADC_SCLK / ADC_CSn  out  1 each  bit-banged ADC serial configuration lines.
REQ-010 LED_ARMED / LED_CAP  out  1 each  show the armed flag and the capturing flag.
REQ-011 LED_CLK1FAIL / LED_CLK2FAIL  out  1 each  tied to 0.
REQ-012 FPGA_TRIGOUT  out  1  capture indicator (see Configuration).
REQ-013 USBIOHS2, FPGA_BONUS1-4, SAM_*, and target_* (PDID, PDIC, nRST, MISO, MOSI, SCK, io1-4, hs1-2)  inout  1 each  held at Z.

Function
REQ-014 Write: on each rising edge where USB_CEn=0 and USB_WRn=0, USB_Data is stored into the register at USB_Addr.
REQ-015 Read: while USB_CEn=0 and USB_RDn=0, USB_Data drives a value registered one cycle earlier from the register at USB_Addr.
REQ-016 Addresses not defined below SHALL ignore writes and read 0x00.
REQ-017 0x00 GAIN: 8-bit read/write register, no internal effect.
REQ-018 0x01 SETTINGS: read/write register.
- bit0 = soft reset; while it is 1 the block behaves as in REQ-029, except that SETTINGS itself keeps its value.
- bit3 = arm.
- bit6 = trigger-now.
REQ-019 0x02 STATUS: read-only.
- bit0 = armed; bit1 = capture done; bit2 = buffer empty; other bits 0.
REQ-020 0x03 DATA: read-only; each read returns the next buffered sample.
- The buffer pops on the cycle USB_RDn returns high after a read of 0x03.
- A read of the empty buffer returns 0x00 and does not pop.
REQ-021 0x04 ECHO: 8-bit read/write scratch register.
REQ-022 0x3C ADCSER: read/write register.
- bit0 drives ADC_SDIO; bit4 drives ADC_SCLK; bit6 drives ADC_CSn.
- Bit7 reads ADC_OVR_SDOUT; other bits read as written.
REQ-023 Arming: a write to SETTINGS where bit3 goes from 0 to 1 SHALL:
- set the armed flag;
- clear the capture-done flag;
- flush the sample buffer.
REQ-024 Triggering: a SETTINGS write with bit6=1 while armed starts a capture on the next cycle; with the block not armed the trigger SHALL be ignored.
REQ-025 Capture: 64 consecutive cycles, writing sample k = k[7:0] (k=0..63) into a 64x8 FIFO.
- Afterwards: capturing=0, armed=0, done=1.
REQ-026 A re-arm or trigger during a capture SHALL be ignored.
REQ-027 Reads of DATA during a capture return samples already written.

Reset
REQ-028 reset=1 or SETTINGS bit0=1 SHALL act synchronously.
REQ-029 The reset state SHALL be:
- all registers 0x00 (SETTINGS only on port reset);
- FIFO empty;
- armed, capturing and done all 0;
- ADC_CSn=0, ADC_SCLK=0, ADC_SDIO=0;
- USB_Data at Z.
REQ-030 A reset during a capture SHALL abort the capture and empty the buffer.

Configuration
REQ-031 Macro CWHUSKY_TRIGOUT_EN:
- If defined, FPGA_TRIGOUT equals the capturing flag.
- If undefined, FPGA_TRIGOUT is constant 0.

Verification
REQ-032 Write 0x04=0xA5, then read 0x04 -> 0xA5; read 0x00 after reset -> 0x00.
REQ-033 Write 0x01: 0x00, 0x01, 0x00 -> STATUS reads 0x04 (empty) and all registers read 0x00.
REQ-034 Write 0x3C sequence 0x41,0x01,0x00,0x11,0x10 -> the (CSn, SCLK, SDIO) lines follow 1/0/1, 0/0/1, 0/0/0, 0/1/1, 0/1/0.
REQ-035 Write 0x01=0x08, then 0x48, wait 1000 cycles -> STATUS=0x02 and 20 DATA reads return 0x00..0x13 in order.
REQ-036 A trigger with the block not armed (0x01=0x40) -> STATUS stays 0x04 and DATA reads 0x00.
REQ-037 Assert reset mid-capture -> buffer empty, LED_CAP=0 and FPGA_TRIGOUT=0 on the next cycle.
